// File: rtl/shift_cmd_sequencer.sv
// Shift command front-end: FIFO-buffered commands split into <=7-bit passes through an external barrel shifter.
// Optional SHIFT_STATS_EN adds a saturating completed-command counter (cmd_count, CNT_W bits).
package shift_cmd_sequencer_pkg;
    typedef struct packed {
        logic [7:0] data;
        logic [3:0] amt;
        logic       dir;
    } cmd_t;
endpackage

module shift_cmd_sequencer
    import shift_cmd_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
`ifdef SHIFT_STATS_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [3:0]       in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [7:0]       sh_in_data,
    output logic [2:0]       sh_shift,
    output logic             sh_dir,
    input  logic [7:0]       sh_out_data
`ifdef SHIFT_STATS_EN
    , output logic [CNT_W-1:0] cmd_count
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic          push;
    logic          pop;
    logic          empty;

    state_t        state;
    state_t        state_n;
    logic [7:0]    work_data;
    logic [7:0]    work_data_n;
    logic [3:0]    rem;
    logic [3:0]    rem_n;
    logic          wdir;
    logic          wdir_n;
    logic          out_valid_n;
    logic [7:0]    out_data_n;
    logic [7:0]    sh_in_data_n;
    logic [2:0]    sh_shift_n;
    logic          sh_dir_n;

    function automatic logic [2:0] step_of(input logic [3:0] r);
        return (r > 4'd7) ? 3'd7 : r[2:0];
    endfunction

    assign push  = in_valid && in_ready;
    assign empty = (count == '0);
    assign pop   = (state == IDLE) && !empty;
    assign head  = mem[rd_ptr];

    // Command storage; no reset needed since count guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_t'{data: in_data, amt: in_amt, dir: in_dir};
        end
    end

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_n;
            in_ready <= (count_n != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            work_data  <= '0;
            rem        <= '0;
            wdir       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            sh_in_data <= '0;
            sh_shift   <= '0;
            sh_dir     <= 1'b0;
        end else begin
            state      <= state_n;
            work_data  <= work_data_n;
            rem        <= rem_n;
            wdir       <= wdir_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            sh_in_data <= sh_in_data_n;
            sh_shift   <= sh_shift_n;
            sh_dir     <= sh_dir_n;
        end
    end

    // Shifter drive is precomputed for the next cycle so it is live exactly while in RUN
    always_comb begin
        state_n      = state;
        work_data_n  = work_data;
        rem_n        = rem;
        wdir_n       = wdir;
        out_valid_n  = out_valid;
        out_data_n   = out_data;
        sh_in_data_n = '0;
        sh_shift_n   = '0;
        sh_dir_n     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    work_data_n  = head.data;
                    rem_n        = head.amt;
                    wdir_n       = head.dir;
                    sh_in_data_n = head.data;
                    sh_shift_n   = step_of(head.amt);
                    sh_dir_n     = head.dir;
                    state_n      = RUN;
                end
            end
            RUN: begin
                work_data_n = sh_out_data;
                rem_n       = rem - 4'(step_of(rem));
                if (rem_n == 4'd0) begin
                    state_n     = DONE;
                    out_valid_n = 1'b1;
                    out_data_n  = sh_out_data;
                end else begin
                    sh_in_data_n = sh_out_data;
                    sh_shift_n   = step_of(rem_n);
                    sh_dir_n     = wdir;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef SHIFT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_count <= '0;
        end else if (out_valid && out_ready && (cmd_count != '1)) begin
            cmd_count <= cmd_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: directed commands, queue-based result model, per-cycle output checks.
// Covers SHIFT_STATS_EN when that macro is defined for the build.
module tb_shift_cmd_sequencer;

    localparam int unsigned TB_CNT_W = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_amt;
    logic       in_dir;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] sh_in_data;
    logic [2:0] sh_shift;
    logic       sh_dir;
    logic [7:0] sh_out_data;
`ifdef SHIFT_STATS_EN
    logic [TB_CNT_W-1:0] cmd_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         mcnt = 0;
    bit         stalled = 0;
    logic [7:0] held = '0;
    logic [7:0] bp_exp [5];

    always #5 clk = ~clk;

    // Stand-in for the downstream combinational barrel shifter
    assign sh_out_data = sh_dir ? (sh_in_data >> sh_shift) : (sh_in_data << sh_shift);

    shift_cmd_sequencer #(
        .DEPTH(4)
`ifdef SHIFT_STATS_EN
        , .CNT_W(TB_CNT_W)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sh_in_data(sh_in_data), .sh_shift(sh_shift), .sh_dir(sh_dir), .sh_out_data(sh_out_data)
`ifdef SHIFT_STATS_EN
        , .cmd_count(cmd_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic [3:0] a, input logic dir);
        int v;
        v = int'(d);
        return dir ? 8'(v >> a) : 8'(v << a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle checks against the queue model
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mcnt    = 0;
            stalled = 0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(held));
            end
            if (out_valid) begin
                chk("sh_idle_zero", {20'd0, sh_in_data, sh_shift, sh_dir}, 0);
            end
`ifdef SHIFT_STATS_EN
            chk("cmd_count", 32'(cmd_count), 32'(mcnt));
`endif
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_amt, in_dir));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("model_result", 32'(out_data), 32'(exp_q.pop_front()));
                end
                if (mcnt < (1 << TB_CNT_W) - 1) mcnt++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
        end
    end

    // One command from an idle engine; seq holds pass amounts {s2,s1,s0}
    task automatic do_cmd(input logic [7:0] d, input logic [3:0] a, input logic dir,
                          input int np, input logic [8:0] seq, input logic [7:0] expd);
        chk("accept_ready", 32'(in_ready), 1);
        in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dir;
        tick();
        in_valid = 1'b0;
        chk("pre_run_valid", 32'(out_valid), 0);
        tick();
        for (int p = 0; p < np; p++) begin
            chk("pass_shift", 32'(sh_shift), 32'(seq[3*p +: 3]));
            chk("pass_dir", 32'(sh_dir), 32'(dir));
            if (p == 0) chk("pass_first_data", 32'(sh_in_data), 32'(d));
            chk("pass_no_valid", 32'(out_valid), 0);
            tick();
        end
        chk("result_valid", 32'(out_valid), 1);
        chk("result_data", 32'(out_data), 32'(expd));
        tick();
        chk("result_dropped", 32'(out_valid), 0);
    endtask

    initial begin
        int acc;
        int got;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0; out_ready = 1'b1;
        bp_exp[0] = 8'h02; bp_exp[1] = 8'h0F; bp_exp[2] = 8'hF0; bp_exp[3] = 8'h00; bp_exp[4] = 8'h18;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_sh", {20'd0, sh_in_data, sh_shift, sh_dir}, 0);
        tick();
        rst = 1'b0;
        tick();

        do_cmd(8'h81, 4'd1,  1'b0, 1, {3'd0, 3'd0, 3'd1}, 8'h02);
        do_cmd(8'hF0, 4'd4,  1'b1, 1, {3'd0, 3'd0, 3'd4}, 8'h0F);
        do_cmd(8'hA5, 4'd0,  1'b0, 1, {3'd0, 3'd0, 3'd0}, 8'hA5);
`ifdef SHIFT_STATS_EN
        chk("stats_three", 32'(cmd_count), 3);
`endif
        do_cmd(8'hFF, 4'd15, 1'b1, 3, {3'd1, 3'd7, 3'd7}, 8'h00);
        do_cmd(8'hFF, 4'd9,  1'b0, 2, {3'd0, 3'd2, 3'd7}, 8'h00);
        do_cmd(8'h80, 4'd7,  1'b1, 1, {3'd0, 3'd0, 3'd7}, 8'h01);

        // Backpressure: six back-to-back offers, five fit
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            case (k)
                0: begin in_data = 8'h81; in_amt = 4'd1;  in_dir = 1'b0; end
                1: begin in_data = 8'hF0; in_amt = 4'd4;  in_dir = 1'b1; end
                2: begin in_data = 8'h3C; in_amt = 4'd2;  in_dir = 1'b0; end
                3: begin in_data = 8'hFF; in_amt = 4'd15; in_dir = 1'b1; end
                4: begin in_data = 8'hC3; in_amt = 4'd3;  in_dir = 1'b1; end
                default: begin in_data = 8'h11; in_amt = 4'd1; in_dir = 1'b0; end
            endcase
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 5);
        chk("bp_ready_low", 32'(in_ready), 0);
        repeat (3) tick();
        chk("bp_stall_valid", 32'(out_valid), 1);
        chk("bp_stall_data", 32'(out_data), 32'h02);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 80 && got < 5; c++) begin
            if (out_valid) begin
                chk("bp_drain_data", 32'(out_data), 32'(bp_exp[got]));
                got++;
            end
            tick();
        end
        chk("bp_drained", 32'(got), 5);
        tick();
        chk("bp_ready_back", 32'(in_ready), 1);
`ifdef SHIFT_STATS_EN
        chk("stats_saturated", 32'(cmd_count), 7);
`endif

        // Reset during the second pass of an amt=15 command
        in_valid = 1'b1; in_data = 8'hFF; in_amt = 4'd15; in_dir = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_run_shift", 32'(sh_shift), 7);
        rst = 1'b1;
        #1;
        chk("arst_sh", {20'd0, sh_in_data, sh_shift, sh_dir}, 0);
        chk("arst_out", {23'd0, out_valid, out_data}, 0);
        chk("arst_in_ready", 32'(in_ready), 1);
`ifdef SHIFT_STATS_EN
        chk("arst_count", 32'(cmd_count), 0);
`endif
        tick();
        rst = 1'b0;
        tick();
        do_cmd(8'h01, 4'd3, 1'b0, 1, {3'd0, 3'd0, 3'd3}, 8'h08);
        repeat (3) tick();
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

endmodule
